// File: rtl/fetch_ifid_stage.sv
// Purpose : instruction fetch (PC + imem req/ack) feeding the IF/ID register of the decoder.
// Latency : a word acked in cycle N is on id_* after edge N+1; zero-wait memory sustains 1 instr/clk.
// Backpressure: id_stall with a valid IF/ID slot parks one acked word in a skid entry and drops imem_req.
// Ports   : clk/rst (async active-low); imem_req/imem_addr/imem_ack/imem_rdata fetch handshake;
//           id_stall from ID; redirect_valid/redirect_pc flush+refetch; id_Instruction/id_pc4/id_valid out.
module fetch_ifid_stage #(
  parameter int                I_SIZE   = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [I_SIZE-1:0] imem_rdata,
  input  logic              id_stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [I_SIZE-1:0] id_Instruction,
  output logic [ADDR_W-1:0] id_pc4,
  output logic              id_valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_SKID = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] drop_addr;   // address of the in-flight request being discarded
  logic [I_SIZE-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_pc4;

  logic              slot_free;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] redirect_target;

  // The request must stay on its original address in DROP until the memory
  // answers, even though pc already points at the redirect target.
  assign imem_req        = (state == S_RUN) || (state == S_DROP);
  assign imem_addr       = (state == S_DROP) ? drop_addr : pc;
  assign slot_free       = !id_valid || !id_stall;
  assign pc_plus4        = pc + WORD_BYTES;
  assign redirect_target = redirect_pc & ALIGN_MASK;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      pc             <= RESET_PC;
      drop_addr      <= RESET_PC;
      skid_instr     <= '0;
      skid_pc4       <= '0;
      id_Instruction <= '0;
      id_pc4         <= '0;
      id_valid       <= 1'b0;
    end else if (redirect_valid && (state != S_IDLE)) begin
      // Flush wins over stall; the skid entry is implicitly emptied by leaving SKID.
      pc             <= redirect_target;
      id_valid       <= 1'b0;
      id_Instruction <= '0;
      if (imem_req && !imem_ack) begin
        state <= S_DROP;
        // A second redirect while already dropping must keep the original address.
        if (state != S_DROP) drop_addr <= pc;
      end else begin
        state <= S_RUN;
      end
    end else begin
      case (state)
        S_IDLE: state <= S_RUN;
        S_RUN: begin
          if (imem_ack) begin
            pc <= pc_plus4;
            if (slot_free) begin
              id_Instruction <= imem_rdata;
              id_pc4         <= pc_plus4;
              id_valid       <= 1'b1;
            end else begin
              skid_instr <= imem_rdata;
              skid_pc4   <= pc_plus4;
              state      <= S_SKID;
            end
          end else if (slot_free) begin
            id_valid <= 1'b0;
          end
        end
        S_SKID: begin
          // id_valid is always 1 here, so slot_free reduces to !id_stall.
          if (slot_free) begin
            id_Instruction <= skid_instr;
            id_pc4         <= skid_pc4;
            id_valid       <= 1'b1;
            state          <= S_RUN;
          end
        end
        default: begin  // S_DROP
          if (slot_free) id_valid <= 1'b0;
          if (imem_ack)  state    <= S_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Purpose : self-checking bench for fetch_ifid_stage (cycle table + scoreboarded streaming).
// Latency : n/a (testbench).
// Backpressure: drives random id_stall and memory wait states against an in-order scoreboard.
module tb_fetch_ifid_stage;

  logic        clk = 1'b0;
  logic        rst1, rst2;
  logic        ack, stall, rv;
  logic [31:0] rdata, rpc;
  logic        req1, req2, vld1, vld2;
  logic [31:0] addr1, addr2, ins1, ins2, pc41, pc42;
  logic        sel;

  logic        o_req, o_vld;
  logic [31:0] o_addr, o_ins, o_pc4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_ifid_stage #(.I_SIZE(32), .ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst1), .imem_req(req1), .imem_addr(addr1), .imem_ack(ack),
    .imem_rdata(rdata), .id_stall(stall), .redirect_valid(rv), .redirect_pc(rpc),
    .id_Instruction(ins1), .id_pc4(pc41), .id_valid(vld1));

  fetch_ifid_stage #(.I_SIZE(32), .ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2), .imem_ack(ack),
    .imem_rdata(rdata), .id_stall(stall), .redirect_valid(rv), .redirect_pc(rpc),
    .id_Instruction(ins2), .id_pc4(pc42), .id_valid(vld2));

  assign o_req  = sel ? req2  : req1;
  assign o_addr = sel ? addr2 : addr1;
  assign o_vld  = sel ? vld2  : vld1;
  assign o_ins  = sel ? ins2  : ins1;
  assign o_pc4  = sel ? pc42  : pc41;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ins;
    logic [31:0] pc4;
  } vec_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc4;
  } exp_t;

  vec_t tv[31];
  exp_t sb_q[$];

  function automatic vec_t mk(logic r, logic a, logic [31:0] d, logic s, logic v, logic [31:0] p,
                              logic e_req, logic [31:0] e_addr, logic e_vld, logic [31:0] e_ins,
                              logic [31:0] e_pc4);
    vec_t t;
    t.rst = r; t.ack = a; t.rdata = d; t.stall = s; t.rv = v; t.rpc = p;
    t.req = e_req; t.addr = e_addr; t.vld = e_vld; t.ins = e_ins; t.pc4 = e_pc4;
    return t;
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return 32'h2000_0001 + (a >> 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    ack = 1'b0; rdata = 32'hDEAD_BEEF; stall = 1'b0; rv = 1'b0; rpc = '0;
  endtask

  // Behavioural memory with random wait states; every acked word is pushed as the
  // next expected ID-stage instruction, popped when ID actually accepts one.
  task automatic stream(input int cycles, input int wait_max, input int stall_pct);
    int   ws;
    int   drain;
    exp_t e;
    ws = 0;
    for (int c = 0; c < cycles; c++) begin
      stall = ($urandom_range(0, 99) < stall_pct);
      if (o_vld && !stall) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_instr", o_ins, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("sb_instr", o_ins, e.ins);
          chk("sb_pc4", o_pc4, e.pc4);
        end
      end
      if (o_req && ws == 0) begin
        ack   = 1'b1;
        rdata = mem_word(o_addr);
        sb_q.push_back('{ins: mem_word(o_addr), pc4: o_addr + 32'd4});
        ws    = $urandom_range(0, wait_max);
      end else begin
        ack   = 1'b0;
        rdata = 32'hDEAD_BEEF;
        if (o_req) ws--;
      end
      @(negedge clk);
    end
    ack = 1'b0; stall = 1'b0;
    drain = 0;
    while (sb_q.size() != 0 && drain < 20) begin
      if (o_vld) begin
        e = sb_q.pop_front();
        chk("sb_instr", o_ins, e.ins);
        chk("sb_pc4", o_pc4, e.pc4);
      end
      @(negedge clk);
      drain++;
    end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    idle_inputs();

    //              rst ack rdata          stl rv  rpc            req addr           vld ins            pc4
    tv[0]  = mk(1'b0,1'b0,32'h0,          1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0);
    tv[1]  = mk(1'b0,1'b0,32'h0,          1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0);
    tv[2]  = mk(1'b1,1'b0,32'h0,          1'b0,1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0,        32'h0);
    tv[3]  = mk(1'b1,1'b1,32'h2000_0001,  1'b0,1'b0,32'h0,        1'b1,32'h4,        1'b1,32'h2000_0001,32'h4);
    tv[4]  = mk(1'b1,1'b1,32'h2000_0002,  1'b0,1'b0,32'h0,        1'b1,32'h8,        1'b1,32'h2000_0002,32'h8);
    tv[5]  = mk(1'b1,1'b1,32'h2000_0003,  1'b0,1'b0,32'h0,        1'b1,32'hC,        1'b1,32'h2000_0003,32'hC);
    tv[6]  = mk(1'b1,1'b1,32'h2000_0004,  1'b1,1'b0,32'h0,        1'b0,32'h10,       1'b1,32'h2000_0003,32'hC);
    tv[7]  = mk(1'b1,1'b0,32'h0,          1'b1,1'b0,32'h0,        1'b0,32'h10,       1'b1,32'h2000_0003,32'hC);
    tv[8]  = mk(1'b1,1'b0,32'h0,          1'b1,1'b0,32'h0,        1'b0,32'h10,       1'b1,32'h2000_0003,32'hC);
    tv[9]  = mk(1'b1,1'b0,32'h0,          1'b0,1'b0,32'h0,        1'b1,32'h10,       1'b1,32'h2000_0004,32'h10);
    tv[10] = mk(1'b1,1'b0,32'h0,          1'b0,1'b0,32'h0,        1'b1,32'h10,       1'b0,32'h2000_0004,32'h10);
    tv[11] = mk(1'b1,1'b1,32'h2000_0005,  1'b0,1'b0,32'h0,        1'b1,32'h14,       1'b1,32'h2000_0005,32'h14);
    tv[12] = mk(1'b1,1'b1,32'h2000_0006,  1'b0,1'b1,32'h0000_0103,1'b1,32'h100,      1'b0,32'h0,        32'h14);
    tv[13] = mk(1'b1,1'b1,32'hAAAA_0001,  1'b0,1'b0,32'h0,        1'b1,32'h104,      1'b1,32'hAAAA_0001,32'h104);
    tv[14] = mk(1'b1,1'b0,32'h0,          1'b0,1'b1,32'h0000_0208,1'b1,32'h104,      1'b0,32'h0,        32'h104);
    tv[15] = mk(1'b1,1'b0,32'h0,          1'b0,1'b0,32'h0,        1'b1,32'h104,      1'b0,32'h0,        32'h104);
    tv[16] = mk(1'b1,1'b1,32'hBBBB_0000,  1'b0,1'b0,32'h0,        1'b1,32'h208,      1'b0,32'h0,        32'h104);
    tv[17] = mk(1'b1,1'b0,32'h0,          1'b0,1'b0,32'h0,        1'b1,32'h208,      1'b0,32'h0,        32'h104);
    tv[18] = mk(1'b1,1'b0,32'h0,          1'b0,1'b0,32'h0,        1'b1,32'h208,      1'b0,32'h0,        32'h104);
    tv[19] = mk(1'b1,1'b1,32'hCCCC_0001,  1'b0,1'b0,32'h0,        1'b1,32'h20C,      1'b1,32'hCCCC_0001,32'h20C);
    tv[20] = mk(1'b1,1'b1,32'hDDDD_0000,  1'b1,1'b1,32'h0000_0300,1'b1,32'h300,      1'b0,32'h0,        32'h20C);
    tv[21] = mk(1'b1,1'b1,32'h1111_0000,  1'b1,1'b0,32'h0,        1'b1,32'h304,      1'b1,32'h1111_0000,32'h304);
    tv[22] = mk(1'b1,1'b1,32'h2222_0000,  1'b1,1'b0,32'h0,        1'b0,32'h308,      1'b1,32'h1111_0000,32'h304);
    tv[23] = mk(1'b1,1'b0,32'h0,          1'b1,1'b1,32'h0000_0400,1'b1,32'h400,      1'b0,32'h0,        32'h304);
    tv[24] = mk(1'b1,1'b1,32'h4444_0000,  1'b0,1'b0,32'h0,        1'b1,32'h404,      1'b1,32'h4444_0000,32'h404);
    tv[25] = mk(1'b1,1'b0,32'h0,          1'b0,1'b1,32'h0000_0500,1'b1,32'h404,      1'b0,32'h0,        32'h404);
    tv[26] = mk(1'b1,1'b0,32'h0,          1'b0,1'b1,32'h0000_0600,1'b1,32'h404,      1'b0,32'h0,        32'h404);
    tv[27] = mk(1'b1,1'b1,32'hEEEE_0000,  1'b0,1'b0,32'h0,        1'b1,32'h600,      1'b0,32'h0,        32'h404);
    tv[28] = mk(1'b0,1'b0,32'h0,          1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0);
    tv[29] = mk(1'b1,1'b1,32'hFFFF_0000,  1'b0,1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0,        32'h0);
    tv[30] = mk(1'b1,1'b1,32'h2000_0001,  1'b0,1'b0,32'h0,        1'b1,32'h4,        1'b1,32'h2000_0001,32'h4);

    @(negedge clk);
    for (int i = 0; i < 31; i++) begin
      rst1 = tv[i].rst; ack = tv[i].ack; rdata = tv[i].rdata;
      stall = tv[i].stall; rv = tv[i].rv; rpc = tv[i].rpc;
      @(negedge clk);
      chk($sformatf("v%0d_imem_req", i),  32'(o_req), 32'(tv[i].req));
      chk($sformatf("v%0d_imem_addr", i), o_addr,     tv[i].addr);
      chk($sformatf("v%0d_id_valid", i),  32'(o_vld), 32'(tv[i].vld));
      chk($sformatf("v%0d_id_instr", i),  o_ins,      tv[i].ins);
      chk($sformatf("v%0d_id_pc4", i),    o_pc4,      tv[i].pc4);
    end

    // Streaming: zero-wait/no-stall, then random wait states and stalls.
    idle_inputs(); rst1 = 1'b0; sb_q.delete();
    @(negedge clk); rst1 = 1'b1; @(negedge clk);
    stream(10, 0, 0);
    idle_inputs(); rst1 = 1'b0; sb_q.delete();
    @(negedge clk); rst1 = 1'b1; @(negedge clk);
    stream(400, 2, 40);

    // PC wrap with RESET_PC = 0xFFFF_FFFC.
    idle_inputs(); rst1 = 1'b0; sel = 1'b1; rst2 = 1'b0;
    @(negedge clk);
    chk("wrap_reset_req",  32'(o_req), 32'd0);
    chk("wrap_reset_addr", o_addr, 32'hFFFF_FFFC);
    rst2 = 1'b1;
    @(negedge clk);
    chk("wrap_first_req",  32'(o_req), 32'd1);
    chk("wrap_first_addr", o_addr, 32'hFFFF_FFFC);
    ack = 1'b1; rdata = mem_word(32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_id_pc4",   o_pc4, 32'h0);
    chk("wrap_id_valid", 32'(o_vld), 32'd1);
    chk("wrap_id_instr", o_ins, 32'h6000_0000);
    chk("wrap_next_addr", o_addr, 32'h0);
    rdata = mem_word(32'h0);
    @(negedge clk);
    chk("wrap_id_pc4_2",  o_pc4, 32'h4);
    chk("wrap_id_instr2", o_ins, 32'h2000_0001);
    idle_inputs();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
